// File: rtl/intr_pkg.sv
// intr_pkg: shared FSM state type and cause-width helper for intr_ctrl
package intr_pkg;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;
  function automatic int cause_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/intr_edge_det.sv
// intr_edge_det: per-source rising-edge detector
// Defining INTR_SYNC_EN inserts a 2-flop synchronizer ahead of the history flop.
module intr_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic src,
  output logic rise
);
  logic s, hist_q, hist_d;
`ifdef INTR_SYNC_EN
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], src};
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync_q <= '0;
    else sync_q <= sync_d;
  assign s = sync_q[1];
`else
  assign s = src;
`endif
  always_comb hist_d = s;
  // history resets low so a source already high at release yields one event
  always_ff @(posedge clk or negedge reset)
    if (!reset) hist_q <= 1'b0;
    else hist_q <= hist_d;
  assign rise = s & ~hist_q;
endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-triggered interrupt controller, fixed priority (index 0 highest), no nesting
// Defining INTR_SYNC_EN adds a 2-flop input synchronizer per source.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int               N_SRC    = 4,
  parameter logic [N_SRC-1:0] MASK_RST = '0,
  localparam int              CAUSE_W  = cause_w(N_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   irq_src,
  input  logic               mask_we,
  input  logic [N_SRC-1:0]   mask_wdata,
  input  logic               int_ack,
  input  logic               eret,
  output logic               int_req,
  output logic [CAUSE_W-1:0] int_cause,
  output logic [N_SRC-1:0]   pending,
  output logic [N_SRC-1:0]   mask,
  output logic               in_service
);
  state_e state_q, state_d;
  logic [CAUSE_W-1:0] cause_q, cause_d, enc;
  logic [N_SRC-1:0] pending_q, pending_d, mask_q, mask_d, rise, elig, clr;
  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    intr_edge_det u_det (.clk(clk), .reset(reset), .src(irq_src[g]), .rise(rise[g]));
  end
  assign elig = pending_q & ~mask_q;
  always_comb begin
    enc = '0;
    for (int i = N_SRC - 1; i >= 0; i--) if (elig[i]) enc = CAUSE_W'(i);
  end
  // a new edge on the acknowledged source outranks the clear
  always_comb begin
    clr       = (state_q == REQ && int_ack) ? N_SRC'(1) << cause_q : '0;
    pending_d = (pending_q & ~clr) | rise;
    mask_d    = mask_we ? mask_wdata : mask_q;
  end
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: if (|elig) begin
        state_d = REQ;
        cause_d = enc;
      end
      REQ:     state_d = int_ack ? SERVICE : REQ;
      SERVICE: state_d = eret ? IDLE : SERVICE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      cause_q   <= '0;
      pending_q <= '0;
      mask_q    <= MASK_RST;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  assign int_req    = state_q == REQ;
  assign in_service = state_q == SERVICE;
  assign int_cause  = cause_q;
  assign pending    = pending_q;
  assign mask       = mask_q;
endmodule
